pid_steering_core: RTL and testbench

Fixed-point PID controller that consumes the signed steering error produced by the mid-line error stage and produces a saturated steering command for the motor/servo driver. The block detects each new error sample, updates an anti-windup integrator and a derivative history, and emits one command per sample through a short multi-cycle pipeline. It sits between the vision error stage and the actuator interface inside `pid_controller/`.

---
 rtl/pid_pkg.sv | 29 ++
 rtl/rising_edge_detect.sv | 32 +++
 rtl/pid_steering_core.sv | 181 ++++++++++++++++++
 tb/tb_pid_steering_core.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared types, widths and the saturating clamp helper for the PID steering controller.
package pid_pkg;

  // Products and the three-term sum share one 40-bit signed datapath width.
  localparam int unsigned SumWidth  = 40;
  localparam int unsigned ProdWidth = SumWidth;

  typedef logic signed [SumWidth-1:0]  acc_t;
  typedef logic signed [ProdWidth-1:0] prod_t;

  typedef enum logic [1:0] {
    StIdle,
    StMult,
    StSum,
    StSat
  } pid_state_e;

  // Used for the error input, the integrator and the output command.
  function automatic acc_t clamp(input acc_t val, input acc_t lo, input acc_t hi);
    if (val < lo) begin
      return lo;
    end else if (val > hi) begin
      return hi;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// Registered rising-edge detector. The first cycle after reset release is ignored, so a
// level already high at release does not count as an edge until it falls and rises again.
module rising_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic pulse_o
);

  logic level_d, level_q;
  logic armed_d, armed_q;

  // Next-state: track the previous level and arm after the first sampled cycle.
  always_comb begin
    level_d = level_i;
    armed_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      level_q <= level_d;
      armed_q <= armed_d;
    end
  end

  assign pulse_o = armed_q & level_i & ~level_q;

endmodule

// File: rtl/pid_steering_core.sv
// Fixed-point PID steering controller: one saturated command per rising edge of error_ready,
// delivered three cycles after the trigger through MULT, SUM and SAT stages.
// Build option: define PID_DERIV_EN to include the derivative (KD) path.
module pid_steering_core
  import pid_pkg::*;
#(
  parameter logic signed [15:0] KP        = 16'sd256,
  parameter logic signed [15:0] KI        = 16'sd0,
  parameter logic signed [15:0] KD        = 16'sd0,
  parameter int                 FRAC_BITS = 8,
  parameter int                 ERR_LIMIT = 1023,
  parameter int                 INT_LIMIT = 4096,
  parameter int                 OUT_MIN   = -1000,
  parameter int                 OUT_MAX   = 1000,
  parameter int unsigned        OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic signed [31:0]          error,
  input  logic                        error_ready,
  input  logic                        clear,
  output logic signed [OUT_WIDTH-1:0] control,
  output logic                        control_valid,
  output logic                        busy,
  output logic                        overrun
);

  pid_state_e state_d, state_q;
  acc_t  integ_d, integ_q;
  acc_t  e_d, e_q;
  acc_t  e_prev_d, e_prev_q;
  logic  first_d, first_q;
  prod_t p_d, p_q;
  prod_t i_d, i_q;
  prod_t d_term;
  acc_t  sum_d, sum_q;
  logic signed [OUT_WIDTH-1:0] control_d, control_q;
  logic  valid_d, valid_q;
  logic  overrun_d, overrun_q;
  logic  clr_pend_d, clr_pend_q;
  logic  clear_now;
  acc_t  e_clamp;
  logic  trigger;

`ifdef PID_DERIV_EN
  acc_t  de_d, de_q;
  prod_t dprod_d, dprod_q;
  assign d_term = dprod_q;
`else
  logic unused_kd;
  assign unused_kd = ^KD;
  assign d_term    = '0;
`endif

  rising_edge_detect u_edge (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .level_i (error_ready),
    .pulse_o (trigger)
  );

  // Next-state: clear handling, sample capture and the three pipeline stages.
  always_comb begin
    state_d    = state_q;
    integ_d    = integ_q;
    e_d        = e_q;
    e_prev_d   = e_prev_q;
    first_d    = first_q;
    p_d        = p_q;
    i_d        = i_q;
    sum_d      = sum_q;
    control_d  = control_q;
    valid_d    = 1'b0;
    overrun_d  = overrun_q;
    clr_pend_d = clr_pend_q;
`ifdef PID_DERIV_EN
    de_d       = de_q;
    dprod_d    = dprod_q;
`endif
    e_clamp    = clamp(acc_t'(error), acc_t'(-ERR_LIMIT), acc_t'(ERR_LIMIT));
    clear_now  = 1'b0;

    // A clear seen mid-pipeline is held until the final stage so the in-flight sample is
    // unaffected; in IDLE it applies before any sample arriving in the same cycle.
    if (state_q == StIdle || state_q == StSat) begin
      clear_now = clear | clr_pend_q;
    end else if (clear) begin
      clr_pend_d = 1'b1;
    end

    if (clear_now) begin
      integ_d    = '0;
      e_prev_d   = '0;
      first_d    = 1'b1;
      overrun_d  = 1'b0;
      clr_pend_d = 1'b0;
    end

    if (trigger && state_q != StIdle) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          integ_d  = clamp(integ_d + e_clamp, acc_t'(-INT_LIMIT), acc_t'(INT_LIMIT));
`ifdef PID_DERIV_EN
          de_d     = first_d ? '0 : e_clamp - e_prev_d;
`endif
          e_prev_d = e_clamp;
          first_d  = 1'b0;
          e_d      = e_clamp;
          state_d  = StMult;
        end
      end
      StMult: begin
        p_d     = prod_t'(KP) * e_q;
        i_d     = prod_t'(KI) * integ_q;
`ifdef PID_DERIV_EN
        dprod_d = prod_t'(KD) * de_q;
`endif
        state_d = StSum;
      end
      StSum: begin
        sum_d   = (p_q + i_q + d_term) >>> FRAC_BITS;
        state_d = StSat;
      end
      StSat: begin
        control_d = OUT_WIDTH'(clamp(sum_q, acc_t'(OUT_MIN), acc_t'(OUT_MAX)));
        valid_d   = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      integ_q    <= '0;
      e_q        <= '0;
      e_prev_q   <= '0;
      first_q    <= 1'b1;
      p_q        <= '0;
      i_q        <= '0;
      sum_q      <= '0;
      control_q  <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      clr_pend_q <= 1'b0;
`ifdef PID_DERIV_EN
      de_q       <= '0;
      dprod_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      integ_q    <= integ_d;
      e_q        <= e_d;
      e_prev_q   <= e_prev_d;
      first_q    <= first_d;
      p_q        <= p_d;
      i_q        <= i_d;
      sum_q      <= sum_d;
      control_q  <= control_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      clr_pend_q <= clr_pend_d;
`ifdef PID_DERIV_EN
      de_q       <= de_d;
      dprod_q    <= dprod_d;
`endif
    end
  end

  assign control       = control_q;
  assign control_valid = valid_q;
  assign busy          = (state_q != StIdle);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_pid_steering_core.sv
// Scoreboard bench for pid_steering_core: stimulus pushes expected commands computed from
// the controller equations; a monitor pops and compares on every control_valid pulse.
`timescale 1ns/1ps
module tb_pid_steering_core;

  localparam logic signed [15:0] TKP = 16'sd256;
  localparam logic signed [15:0] TKI = 16'sd64;
  localparam logic signed [15:0] TKD = 16'sd128;
  localparam int TFRAC = 8;
  localparam int TERR  = 1023;
  localparam int TINT  = 2000;
  localparam int TOMIN = -1000;
  localparam int TOMAX = 1000;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic signed [31:0] error = '0;
  logic               error_ready = 1'b0;
  logic               clear = 1'b0;
  logic signed [15:0] control;
  logic               control_valid;
  logic               busy;
  logic               overrun;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_q[$];

  // Reference model state.
  longint m_integ = 0;
  longint m_eprev = 0;
  bit     m_first = 1'b1;
  bit     m_ovr = 1'b0;
  int     last_acc = -100;

  pid_steering_core #(
    .KP        (TKP),
    .KI        (TKI),
    .KD        (TKD),
    .FRAC_BITS (TFRAC),
    .ERR_LIMIT (TERR),
    .INT_LIMIT (TINT),
    .OUT_MIN   (TOMIN),
    .OUT_MAX   (TOMAX),
    .OUT_WIDTH (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .error         (error),
    .error_ready   (error_ready),
    .clear         (clear),
    .control       (control),
    .control_valid (control_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Division by 2^FRAC rounding toward minus infinity.
  function automatic longint floor_scale(input longint v);
    longint den;
    den = longint'(1) << TFRAC;
    return (v >= 0) ? (v / den) : -((-v + den - 1) / den);
  endfunction

  function automatic void model_clear();
    m_integ = 0;
    m_eprev = 0;
    m_first = 1'b1;
    m_ovr   = 1'b0;
  endfunction

  // Monitor: every command pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (control_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_control_valid", control_valid, 0);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("control", control, e);
      end
    end
  end

  // Raise error_ready (trigger at the next edge), keep it high for hold extra cycles, drop it.
  // A clear is only issued alongside a sample the controller will accept.
  task automatic sample(input int err, input bit clr_in, input int hold);
    longint e, de, val;
    bit acc, clr;
    acc = (cyc + 1 - last_acc) >= 4;
    clr = clr_in & acc;
    error = err;
    error_ready = 1'b1;
    clear = clr;
    @(posedge clk);
    #1;
    clear = 1'b0;
    if (clr) model_clear();
    if (acc) begin
      last_acc = cyc;
      e = clampl(err, -TERR, TERR);
      m_integ = clampl(m_integ + e, -TINT, TINT);
`ifdef PID_DERIV_EN
      de = m_first ? 0 : e - m_eprev;
`else
      de = 0;
`endif
      m_eprev = e;
      m_first = 1'b0;
      val = floor_scale(longint'(TKP) * e + longint'(TKI) * m_integ + longint'(TKD) * de);
      exp_q.push_back(int'(clampl(val, TOMIN, TOMAX)));
    end else begin
      m_ovr = 1'b1;
    end
    repeat (hold) @(posedge clk);
    #1;
    error_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_clear();
  endtask

  task automatic check_idle(input string tag);
    repeat (5) @(posedge clk);
    #1;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, m_ovr);
    check({tag, "_outstanding"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_control", control, 0);
    check("rst_valid", control_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Proportional and error clamp cases.
    sample(40, 1'b0, 3);
    sample(-25, 1'b0, 3);
    sample(5000, 1'b1, 3);
    sample(-5000, 1'b1, 3);
    // Integrator accumulation up to its limit.
    for (int k = 0; k < 5; k++) sample(900, 1'b0, 2);
    sample(10, 1'b1, 2);
    sample(30, 1'b0, 2);
    check_idle("directed");

    // Level held high gives one command only.
    sample(7, 1'b0, 100);
    check_idle("held_level");

    // Second edge two cycles after the first is dropped and flags overrun.
    sample(3, 1'b0, 0);
    sample(4, 1'b0, 0);
    check_idle("overrun_set");
    clear_pulse();
    check_idle("overrun_clr");

    // Clear during the pipeline is deferred; next sample starts from a cleared state.
    sample(3, 1'b0, 0);
    sample(4, 1'b0, 0);
    sample(30, 1'b0, 0);
    clear_pulse();
    check_idle("pending_clear");
    sample(12, 1'b0, 3);
    sample(-40, 1'b0, 3);
    check_idle("after_clear");

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      int err;
      if ($urandom_range(0, 4) == 0) err = int'($urandom_range(0, 12000)) - 6000;
      else err = int'($urandom_range(0, 2400)) - 1200;
      sample(err, ($urandom_range(0, 9) == 0), int'($urandom_range(0, 5)));
      if (n % 10 == 9) begin
        check_idle("random");
        if (m_ovr) clear_pulse();
      end
    end
    check_idle("random_end");

    // Reset while the sample is in SUM: no command, outputs back to reset values.
    sample(50, 1'b0, 0);
    error_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_control", control, 0);
    check("midrst_valid", control_valid, 0);
    check("midrst_overrun", overrun, 0);
    void'(exp_q.pop_back());
    model_clear();
    last_acc = -100;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    // error_ready already high at release is not a trigger.
    repeat (6) @(posedge clk);
    #1;
    check("release_high_busy", busy, 0);
    error_ready = 1'b0;
    @(posedge clk);
    #1;
    sample(60, 1'b0, 3);
    sample(-60, 1'b0, 3);
    check_idle("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
